// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin arbiter sharing one main-memory block port between icache and dcache
module cache_mem_arbiter #(
   parameter int ADDR_W  = 6,
   parameter int BLOCK_W = 128
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               i_mem_read,
   input  logic [ADDR_W-1:0]  i_mem_address,
   output logic [BLOCK_W-1:0] i_mem_readdata,
   output logic               i_mem_busywait,
   input  logic               d_mem_read,
   input  logic               d_mem_write,
   input  logic [ADDR_W-1:0]  d_mem_address,
   input  logic [BLOCK_W-1:0] d_mem_writedata,
   output logic [BLOCK_W-1:0] d_mem_readdata,
   output logic               d_mem_busywait,
   output logic               mem_read,
   output logic               mem_write,
   output logic [ADDR_W-1:0]  mem_address,
   output logic [BLOCK_W-1:0] mem_writedata,
   input  logic [BLOCK_W-1:0] mem_readdata,
   input  logic               mem_busywait
);

   typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D} state_t;

   state_t               state_q;
   logic                 started_q;
   logic                 last_grant_q;
   logic                 lat_write_q;
   logic [ADDR_W-1:0]    lat_addr_q;
   logic [BLOCK_W-1:0]   lat_wdata_q;
   logic [BLOCK_W-1:0]   rdata_i_q;
   logic [BLOCK_W-1:0]   rdata_d_q;
   logic                 mem_read_q;
   logic                 mem_write_q;
   logic                 d_req;
   logic                 grant_i;

   assign d_req   = d_mem_read | d_mem_write;
   // On a tie the master that did not win last time gets the port.
   assign grant_i = i_mem_read & (~d_req | last_grant_q);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         started_q    <= 1'b0;
         last_grant_q <= 1'b1;
         lat_write_q  <= 1'b0;
         lat_addr_q   <= '0;
         lat_wdata_q  <= '0;
         rdata_i_q    <= '0;
         rdata_d_q    <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               started_q <= 1'b0;
               if (grant_i) begin
                  last_grant_q <= 1'b0;
                  lat_addr_q   <= i_mem_address;
                  lat_wdata_q  <= '0;
                  lat_write_q  <= 1'b0;
                  mem_read_q   <= 1'b1;
                  mem_write_q  <= 1'b0;
                  state_q      <= SERVE_I;
               end else if (d_req) begin
                  last_grant_q <= 1'b1;
                  lat_addr_q   <= d_mem_address;
                  lat_wdata_q  <= d_mem_writedata;
                  lat_write_q  <= d_mem_write;
                  mem_read_q   <= ~d_mem_write;
                  mem_write_q  <= d_mem_write;
                  state_q      <= SERVE_D;
               end
            end
            SERVE_I, SERVE_D: begin
               // A transaction only completes once memory has first signalled busy.
               if (!started_q) begin
                  if (mem_busywait) started_q <= 1'b1;
               end else if (!mem_busywait) begin
                  if (!lat_write_q) begin
                     if (state_q == SERVE_I) rdata_i_q <= mem_readdata;
                     else                    rdata_d_q <= mem_readdata;
                  end
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  lat_addr_q  <= '0;
                  lat_wdata_q <= '0;
                  state_q     <= (state_q == SERVE_I) ? DONE_I : DONE_D;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;
   assign mem_address    = lat_addr_q;
   assign mem_writedata  = lat_wdata_q;
   assign i_mem_readdata = rdata_i_q;
   assign d_mem_readdata = rdata_d_q;
   assign i_mem_busywait = i_mem_read & (state_q != DONE_I);
   assign d_mem_busywait = d_req & (state_q != DONE_D);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - randomized and directed bench for cache_mem_arbiter against a transaction-level model
module tb_cache_mem_arbiter;

   logic         clock;
   logic         reset;
   logic         i_mem_read;
   logic [5:0]   i_mem_address;
   logic [127:0] i_mem_readdata;
   logic         i_mem_busywait;
   logic         d_mem_read;
   logic         d_mem_write;
   logic [5:0]   d_mem_address;
   logic [127:0] d_mem_writedata;
   logic [127:0] d_mem_readdata;
   logic         d_mem_busywait;
   logic         mem_read;
   logic         mem_write;
   logic [5:0]   mem_address;
   logic [127:0] mem_writedata;
   logic [127:0] mem_readdata;
   logic         mem_busywait;

   cache_mem_arbiter dut (
      .clock(clock), .reset(reset),
      .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
      .i_mem_readdata(i_mem_readdata), .i_mem_busywait(i_mem_busywait),
      .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_address(d_mem_address),
      .d_mem_writedata(d_mem_writedata), .d_mem_readdata(d_mem_readdata),
      .d_mem_busywait(d_mem_busywait),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic         w;
      logic [5:0]   a;
      logic [127:0] d;
   } txn_t;

   int           total = 0;
   int           bad = 0;
   int           lat;
   int           pre;
   int           cnt = 0;
   logic         mem_init;
   logic [127:0] mem_arr [64];
   logic [127:0] ref_mem [64];
   bit           model_last;
   txn_t         log_q[$];
   bit           prev_s = 0;
   logic [5:0]   cur_addr = '0;
   bit           addr_moved = 0;

   function automatic logic [127:0] seed(input int a);
      logic [15:0] h;
      if (a == 21) return {16{8'hA5}};
      h = {10'h2A5, 6'(a)};
      return {8{h}};
   endfunction

   // Memory responder: optional idle cycles, then lat busy cycles, then ready.
   assign mem_busywait = (mem_read || mem_write) && (cnt >= pre) && (cnt < pre + lat);
   assign mem_readdata = mem_arr[mem_address];

   always @(posedge clock) begin
      if (mem_init) begin
         for (int a = 0; a < 64; a++) mem_arr[a] <= seed(a);
         cnt <= 0;
      end else if (mem_read || mem_write) begin
         cnt <= cnt + 1;
         if (mem_write && cnt == pre + lat) mem_arr[mem_address] <= mem_writedata;
      end else begin
         cnt <= 0;
      end
   end

   always @(negedge clock) begin
      if ((mem_read || mem_write) && !prev_s) begin
         log_q.push_back('{mem_write, mem_address, mem_writedata});
         cur_addr = mem_address;
      end else if ((mem_read || mem_write) && mem_address != cur_addr) begin
         addr_moved = 1;
      end
      prev_s = mem_read || mem_write;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      model_last = 1'b1;
   endtask

   task automatic run_txn(input bit ireq, input bit dreq, input bit dw, input bit dboth,
                          input logic [5:0] ia, input logic [5:0] da, input logic [127:0] wd,
                          input int l, input int p, input bit chg);
      bit           exp_order[$];
      bit           got_order[$];
      logic [127:0] exp_i = '0;
      logic [127:0] exp_d = '0;
      bit           first_d;
      bit           ip, dp, changed;
      int           n, base, spurious;
      txn_t         e;
      first_d = (ireq && dreq) ? (model_last == 1'b0) : dreq;
      exp_order.push_back(first_d);
      if (ireq && dreq) exp_order.push_back(!first_d);
      foreach (exp_order[k]) begin
         if (!exp_order[k]) exp_i = ref_mem[ia];
         else if (dw)       ref_mem[da] = wd;
         else               exp_d = ref_mem[da];
      end
      model_last = exp_order[exp_order.size()-1];
      base = log_q.size();
      lat = l;
      pre = p;
      i_mem_read = ireq;
      i_mem_address = ia;
      d_mem_read = dreq && (!dw || dboth);
      d_mem_write = dreq && dw;
      d_mem_address = da;
      d_mem_writedata = wd;
      ip = ireq; dp = dreq; n = 0; changed = 0; spurious = 0;
      while ((ip || dp) && n < 400) begin
         @(negedge clock);
         n++;
         if (!ireq && i_mem_busywait) spurious++;
         if (!dreq && d_mem_busywait) spurious++;
         if (chg && !changed && dp && (mem_read || mem_write)) begin
            d_mem_address = 6'h3F;
            changed = 1;
         end
         if (ip && !i_mem_busywait) begin
            ip = 0;
            got_order.push_back(1'b0);
            check("i_rdata", i_mem_readdata, exp_i);
            i_mem_read = 1'b0;
         end
         if (dp && !d_mem_busywait) begin
            dp = 0;
            got_order.push_back(1'b1);
            if (!dw) check("d_rdata", d_mem_readdata, exp_d);
            d_mem_read = 1'b0;
            d_mem_write = 1'b0;
         end
      end
      if (ip || dp) check("timeout", 1, 0);
      check("n_done", got_order.size(), exp_order.size());
      for (int k = 0; k < got_order.size() && k < exp_order.size(); k++)
         check("grant_order", got_order[k], exp_order[k]);
      check("n_txn", log_q.size() - base, exp_order.size());
      for (int k = 0; k < exp_order.size() && base + k < log_q.size(); k++) begin
         e = log_q[base + k];
         check("txn_write", e.w, exp_order[k] ? dw : 1'b0);
         check("txn_addr", e.a, exp_order[k] ? da : ia);
         check("txn_wdata", e.d, exp_order[k] ? wd : '0);
      end
      check("idle_busywait", spurious, 0);
   endtask

   initial begin
      bit           got[$];
      bit           first_d;
      int           n;
      logic [127:0] wd;
      reset = 1'b1; mem_init = 1'b1;
      i_mem_read = 1'b1; i_mem_address = 6'h15;
      d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0; d_mem_writedata = '0;
      lat = 1; pre = 0; model_last = 1'b1;
      for (int a = 0; a < 64; a++) ref_mem[a] = seed(a);

      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         check("rst_mem_read", mem_read, 0);
         check("rst_mem_write", mem_write, 0);
         check("rst_mem_address", mem_address, 0);
         check("rst_mem_wdata", mem_writedata, 0);
         check("rst_i_rdata", i_mem_readdata, 0);
         check("rst_d_rdata", d_mem_readdata, 0);
      end
      mem_init = 1'b0; i_mem_read = 1'b0; reset = 1'b0;
      @(negedge clock);

      run_txn(1, 0, 0, 0, 6'h15, 6'h00, '0, 5, 0, 0);
      check("lone_i_a5", i_mem_readdata, {16{8'hA5}});

      do_reset();
      run_txn(1, 1, 1, 0, 6'h01, 6'h22, {4{32'hDEADBEEF}}, 3, 0, 0);

      // Both masters hold their requests across four transactions.
      first_d = (model_last == 1'b0);
      lat = 2; pre = 0;
      i_mem_read = 1'b1; i_mem_address = 6'h05;
      d_mem_read = 1'b1; d_mem_write = 1'b0; d_mem_address = 6'h06;
      n = 0;
      while (got.size() < 4 && n < 400) begin
         @(negedge clock);
         n++;
         if (!i_mem_busywait) got.push_back(1'b0);
         if (!d_mem_busywait) got.push_back(1'b1);
      end
      i_mem_read = 1'b0; d_mem_read = 1'b0;
      check("rr_count", got.size(), 4);
      for (int k = 0; k < got.size(); k++) check("rr_order", got[k], first_d ^ k[0]);
      check("rr_i_rdata", i_mem_readdata, ref_mem[5]);
      check("rr_d_rdata", d_mem_readdata, ref_mem[6]);
      model_last = !first_d;
      @(negedge clock);

      run_txn(0, 1, 1, 0, 6'h00, 6'h22, {4{32'h0BADF00D}}, 4, 1, 1);
      check("addr_stable", addr_moved, 0);

      for (int it = 0; it < 30; it++) begin
         int  kind;
         bit  dw;
         kind = $urandom_range(0, 2);
         dw = 1'($urandom_range(0, 1));
         wd = {$urandom, $urandom, $urandom, $urandom};
         run_txn(kind != 1, kind != 0, dw, dw & 1'($urandom_range(0, 1)),
                 6'($urandom), 6'($urandom), wd, $urandom_range(1, 6), $urandom_range(0, 2), 0);
         if ($urandom_range(0, 1) == 1) @(negedge clock);
      end
      check("addr_stable_rand", addr_moved, 0);

      // Abort an icache read mid-flight, after making last_grant point at icache.
      run_txn(1, 0, 0, 0, 6'h0A, 6'h00, '0, 1, 0, 0);
      lat = 20; pre = 0;
      i_mem_read = 1'b1; i_mem_address = 6'h0B;
      n = 0;
      while (!mem_read && n < 10) begin
         @(negedge clock);
         n++;
      end
      check("abort_started", mem_read, 1);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("abort_mem_read", mem_read, 0);
      check("abort_mem_addr", mem_address, 0);
      check("abort_i_rdata", i_mem_readdata, 0);
      check("abort_d_rdata", d_mem_readdata, 0);
      reset = 1'b0; i_mem_read = 1'b0; model_last = 1'b1;
      @(negedge clock);
      run_txn(1, 1, 0, 0, 6'h0C, 6'h0D, '0, 2, 0, 0);
      run_txn(0, 1, 0, 0, 6'h00, 6'h2E, '0, 3, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
